hazard_scoreboard_unit: RTL and testbench

- Parametrised hazard detection unit for the MIPS pipeline.
- Keeps the existing load-use, branch and jr checks, gated by per-operand "uses" flags so that non-reading instructions no longer cause spurious bubbles.
- Adds a per-register scoreboard for multi-cycle ops (mult/div/FPU), covering RAW/WAW and non-pipelined-unit structural stalls.
- Adds a saturating stall-cycle statistics counter.
- Sits beside the ID stage and drives PC/IF-ID freeze and the control flush mux.

---
 rtl/hazard_scoreboard_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection unit for the MIPS pipeline, placed beside the ID stage.
// Combines the classic load-use / branch / jr checks (gated by operand "uses"
// flags) with a per-register countdown scoreboard for multi-cycle results,
// a structural stall for a non-pipelined multi-cycle unit, and a saturating
// counter of stall cycles.
module hazard_scoreboard_unit #(
    parameter int REG_W        = 5,
    parameter int LAT_W        = 4,
    parameter int PIPELINED_MC = 0,
    parameter int STAT_W       = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [REG_W-1:0]  iID_NumRs,
    input  logic [REG_W-1:0]  iID_NumRt,
    input  logic              iID_UsesRs,
    input  logic              iID_UsesRt,
    input  logic              iID_RegWrite,
    input  logic [REG_W-1:0]  iID_RegDestino,
    input  logic              iID_IsMC,
    input  logic [LAT_W-1:0]  iID_MCLat,
    input  logic              iBranch,
    input  logic              iCJr,
    input  logic              iEX_MemRead,
    input  logic              iEX_RegWrite,
    input  logic [REG_W-1:0]  iEX_RegDestino,
    input  logic              iMEM_MemRead,
    input  logic              iMEM_RegWrite,
    input  logic [REG_W-1:0]  iMEM_RegDestino,
    input  logic              iHold,
    input  logic              iClrStats,
    output logic              oBlockPC,
    output logic              oBlockIFID,
    output logic              oFlushControl,
    output logic              oForwardJr,
    output logic              oForwardPC4,
    output logic              oMCBusy,
    output logic [STAT_W-1:0] oStallCount
);

    localparam int               NREG    = 2 ** REG_W;
    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [REG_W-1:0] REG_RA   = REG_W'(31);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    // True when a nonzero register d is actually read by the ID instruction.
    function automatic logic f_match(
        input logic [REG_W-1:0] d,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rs,
        input logic             uses_rt
    );
        return (d != REG_ZERO) && ((uses_rs && (d == rs)) || (uses_rt && (d == rt)));
    endfunction

    logic [LAT_W-1:0]  r_cnt [NREG];
    logic [LAT_W-1:0]  r_ub;
    logic [STAT_W-1:0] r_stat;

    logic             w_ex_match;
    logic             w_mem_match;
    logic             w_load_use;
    logic             w_branch_ex;
    logic             w_branch_mem;
    logic             w_sb_raw;
    logic             w_sb_waw;
    logic             w_struct;
    logic             w_stall;
    logic             w_issue;
    logic [LAT_W-1:0] w_lat;
    logic             w_fwd_jr;
    logic             w_fwd_pc4;

    // Hazard conditions, issue decision and forwarding selects; reset masks everything.
    always_comb begin
        w_ex_match   = f_match(iEX_RegDestino, iID_NumRs, iID_NumRt, iID_UsesRs, iID_UsesRt);
        w_mem_match  = f_match(iMEM_RegDestino, iID_NumRs, iID_NumRt, iID_UsesRs, iID_UsesRt);
        w_load_use   = iEX_MemRead && iEX_RegWrite && w_ex_match;
        w_branch_ex  = iBranch && iEX_RegWrite && w_ex_match;
        w_branch_mem = (iBranch || iCJr) && iMEM_MemRead && iMEM_RegWrite && w_mem_match;
        w_sb_raw     = (iID_UsesRs && (iID_NumRs != REG_ZERO) && (r_cnt[iID_NumRs] != LAT_ZERO))
                    || (iID_UsesRt && (iID_NumRt != REG_ZERO) && (r_cnt[iID_NumRt] != LAT_ZERO));
        w_sb_waw     = iID_RegWrite && (iID_RegDestino != REG_ZERO)
                    && (r_cnt[iID_RegDestino] != LAT_ZERO);
        w_struct     = (PIPELINED_MC == 0) && iID_IsMC && (r_ub != LAT_ZERO);
        w_stall      = !iRST && (w_load_use || w_branch_ex || w_branch_mem
                                 || w_sb_raw || w_sb_waw || w_struct);
        w_issue      = iID_IsMC && !w_stall && !iHold && !iRST;
        if (iID_MCLat == LAT_ZERO) begin
            w_lat = LAT_ONE;
        end else begin
            w_lat = iID_MCLat;
        end
        w_fwd_jr     = !iRST && iCJr && iEX_RegWrite && !iEX_MemRead
                    && (iEX_RegDestino == iID_NumRs) && (iID_NumRs != REG_ZERO);
        w_fwd_pc4    = !iRST && iCJr && iMEM_RegWrite && (iMEM_RegDestino == REG_RA);
    end

    // Per-register result countdown; a new issue loads the latency over the decrement.
    always_ff @(posedge iCLK) begin
        for (int r = 0; r < NREG; r++) begin
            if (iRST) begin
                r_cnt[r] <= LAT_ZERO;
            end else if (w_issue && iID_RegWrite && (iID_RegDestino != REG_ZERO)
                         && (iID_RegDestino == REG_W'(r))) begin
                r_cnt[r] <= w_lat;
            end else if (r_cnt[r] != LAT_ZERO) begin
                r_cnt[r] <= r_cnt[r] - LAT_ONE;
            end else begin
                r_cnt[r] <= r_cnt[r];
            end
        end
    end

    generate
        if (PIPELINED_MC == 0) begin : g_unit_busy
            // Occupancy of the non-pipelined unit, loaded on every issue regardless of dest.
            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    r_ub <= LAT_ZERO;
                end else if (w_issue) begin
                    r_ub <= w_lat;
                end else if (r_ub != LAT_ZERO) begin
                    r_ub <= r_ub - LAT_ONE;
                end else begin
                    r_ub <= r_ub;
                end
            end
        end else begin : g_no_busy
            assign r_ub = LAT_ZERO;
        end
    endgenerate

    // Stall-cycle statistics: clear wins, otherwise saturating increment on stall.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_stat <= {STAT_W{1'b0}};
        end else if (iClrStats) begin
            r_stat <= {STAT_W{1'b0}};
        end else if (w_stall && (r_stat != {STAT_W{1'b1}})) begin
            r_stat <= r_stat + STAT_W'(1);
        end else begin
            r_stat <= r_stat;
        end
    end

    assign oBlockPC      = w_stall;
    assign oBlockIFID    = w_stall;
    assign oFlushControl = w_stall;
    assign oForwardJr    = w_fwd_jr;
    assign oForwardPC4   = w_fwd_pc4;
    assign oMCBusy       = (r_ub != LAT_ZERO);
    assign oStallCount   = r_stat;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: a table of single-cycle
// combinational vectors plus hand-written multi-cycle sequences. Expected
// values are queued when stimulus is driven and checked on the falling edge.
module tb_hazard_scoreboard_unit;

    localparam int REG_W  = 5;
    localparam int LAT_W  = 4;
    localparam int STAT_W = 4;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic [REG_W-1:0]  iID_NumRs, iID_NumRt, iID_RegDestino;
    logic              iID_UsesRs, iID_UsesRt, iID_RegWrite, iID_IsMC;
    logic [LAT_W-1:0]  iID_MCLat;
    logic              iBranch, iCJr;
    logic              iEX_MemRead, iEX_RegWrite;
    logic [REG_W-1:0]  iEX_RegDestino;
    logic              iMEM_MemRead, iMEM_RegWrite;
    logic [REG_W-1:0]  iMEM_RegDestino;
    logic              iHold, iClrStats;
    logic              oBlockPC, oBlockIFID, oFlushControl;
    logic              oForwardJr, oForwardPC4, oMCBusy;
    logic [STAT_W-1:0] oStallCount;

    hazard_scoreboard_unit #(
        .REG_W(REG_W), .LAT_W(LAT_W), .PIPELINED_MC(0), .STAT_W(STAT_W)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iID_NumRs(iID_NumRs), .iID_NumRt(iID_NumRt),
        .iID_UsesRs(iID_UsesRs), .iID_UsesRt(iID_UsesRt),
        .iID_RegWrite(iID_RegWrite), .iID_RegDestino(iID_RegDestino),
        .iID_IsMC(iID_IsMC), .iID_MCLat(iID_MCLat),
        .iBranch(iBranch), .iCJr(iCJr),
        .iEX_MemRead(iEX_MemRead), .iEX_RegWrite(iEX_RegWrite), .iEX_RegDestino(iEX_RegDestino),
        .iMEM_MemRead(iMEM_MemRead), .iMEM_RegWrite(iMEM_RegWrite), .iMEM_RegDestino(iMEM_RegDestino),
        .iHold(iHold), .iClrStats(iClrStats),
        .oBlockPC(oBlockPC), .oBlockIFID(oBlockIFID), .oFlushControl(oFlushControl),
        .oForwardJr(oForwardJr), .oForwardPC4(oForwardPC4), .oMCBusy(oMCBusy),
        .oStallCount(oStallCount)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic       rst;
        int         rs, rt;
        logic       urs, urt, rw;
        int         dest;
        logic       ismc;
        int         lat;
        logic       brn, cjr;
        logic       exmr, exrw;
        int         exd;
        logic       memmr, memrw;
        int         memd;
        logic       hold, clr;
        int         e_stall, e_fjr, e_fpc4;  // -1 = not checked
        int         e_busy, e_cnt;           // -1 = not checked
        string      name;
    } vec_t;

    typedef struct {
        int    stall, fjr, fpc4, busy, cnt;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic vec_t idle(input string nm);
        vec_t v;
        v.rst = 1'b0; v.rs = 0; v.rt = 0; v.urs = 1'b0; v.urt = 1'b0; v.rw = 1'b0;
        v.dest = 0; v.ismc = 1'b0; v.lat = 0; v.brn = 1'b0; v.cjr = 1'b0;
        v.exmr = 1'b0; v.exrw = 1'b0; v.exd = 0; v.memmr = 1'b0; v.memrw = 1'b0;
        v.memd = 0; v.hold = 1'b0; v.clr = 1'b0;
        v.e_stall = 0; v.e_fjr = 0; v.e_fpc4 = 0; v.e_busy = -1; v.e_cnt = -1;
        v.name = nm;
        return v;
    endfunction

    function automatic vec_t mk(input string nm, input int rs, input int rt,
                                input logic urs, input logic urt, input logic brn, input logic cjr,
                                input logic exmr, input logic exrw, input int exd,
                                input logic memmr, input logic memrw, input int memd,
                                input int es, input int ej, input int ep);
        vec_t v = idle(nm);
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.brn = brn; v.cjr = cjr;
        v.exmr = exmr; v.exrw = exrw; v.exd = exd;
        v.memmr = memmr; v.memrw = memrw; v.memd = memd;
        v.e_stall = es; v.e_fjr = ej; v.e_fpc4 = ep; v.e_busy = 0;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input int act, input int req);
        n_assert++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, check it on the falling edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        iRST = v.rst;
        iID_NumRs = REG_W'(v.rs); iID_NumRt = REG_W'(v.rt);
        iID_UsesRs = v.urs; iID_UsesRt = v.urt; iID_RegWrite = v.rw;
        iID_RegDestino = REG_W'(v.dest); iID_IsMC = v.ismc; iID_MCLat = LAT_W'(v.lat);
        iBranch = v.brn; iCJr = v.cjr;
        iEX_MemRead = v.exmr; iEX_RegWrite = v.exrw; iEX_RegDestino = REG_W'(v.exd);
        iMEM_MemRead = v.memmr; iMEM_RegWrite = v.memrw; iMEM_RegDestino = REG_W'(v.memd);
        iHold = v.hold; iClrStats = v.clr;
        e.stall = v.e_stall; e.fjr = v.e_fjr; e.fpc4 = v.e_fpc4;
        e.busy = v.e_busy; e.cnt = v.e_cnt; e.name = v.name;
        exp_q.push_back(e);
        @(negedge iCLK);
        g = exp_q.pop_front();
        if (g.stall >= 0) begin
            chk(g.name, "BlockPC", int'(oBlockPC), g.stall);
            chk(g.name, "BlockIFID", int'(oBlockIFID), g.stall);
            chk(g.name, "FlushControl", int'(oFlushControl), g.stall);
        end
        if (g.fjr >= 0)  chk(g.name, "ForwardJr", int'(oForwardJr), g.fjr);
        if (g.fpc4 >= 0) chk(g.name, "ForwardPC4", int'(oForwardPC4), g.fpc4);
        if (g.busy >= 0) chk(g.name, "MCBusy", int'(oMCBusy), g.busy);
        if (g.cnt >= 0)  chk(g.name, "StallCount", int'(oStallCount), g.cnt);
        @(posedge iCLK);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        // Combinational vectors (no multi-cycle issue, scoreboard stays empty).
        //            name          rs  rt urs urt brn cjr exmr exrw exd memmr memrw memd  st fj fp
        tbl.push_back(mk("idle",      0,  0, 0,  0,  0,  0,  0,   0,  0,  0,    0,    0,   0, 0, 0));
        tbl.push_back(mk("lu_rs",     8,  0, 1,  0,  0,  0,  1,   1,  8,  0,    0,    0,   1, 0, 0));
        tbl.push_back(mk("lu_after",  8,  0, 1,  0,  0,  0,  0,   0,  0,  0,    0,    0,   0, 0, 0));
        tbl.push_back(mk("lu_nouse",  8,  0, 0,  0,  0,  0,  1,   1,  8,  0,    0,    0,   0, 0, 0));
        tbl.push_back(mk("lu_rt",     3,  8, 0,  1,  0,  0,  1,   1,  8,  0,    0,    0,   1, 0, 0));
        tbl.push_back(mk("lu_zero",   0,  0, 1,  1,  0,  0,  1,   1,  0,  0,    0,    0,   0, 0, 0));
        tbl.push_back(mk("ex_alu",    8,  0, 1,  0,  0,  0,  0,   1,  8,  0,    0,    0,   0, 0, 0));
        tbl.push_back(mk("br_ex",     5,  0, 1,  0,  1,  0,  0,   1,  5,  0,    0,    0,   1, 0, 0));
        tbl.push_back(mk("br_memld",  0,  6, 0,  1,  1,  0,  0,   0,  0,  1,    1,    6,   1, 0, 0));
        tbl.push_back(mk("br_memalu", 0,  6, 0,  1,  1,  0,  0,   0,  0,  0,    1,    6,   0, 0, 0));
        tbl.push_back(mk("jr_fwd",   31,  0, 1,  0,  0,  1,  0,   1, 31,  0,    0,    0,   0, 1, 0));
        tbl.push_back(mk("jr_exld",  31,  0, 1,  0,  0,  1,  1,   1, 31,  0,    0,    0,   1, 0, 0));
        tbl.push_back(mk("jr_jal",   31,  0, 1,  0,  0,  1,  0,   0,  0,  0,    1,   31,   0, 0, 1));
        tbl.push_back(mk("jr_memld", 31,  0, 1,  0,  0,  1,  0,   0,  0,  1,    1,   31,   1, 0, 1));
        tbl.push_back(mk("pc4_nojr", 31,  0, 1,  0,  0,  0,  0,   0,  0,  0,    1,   31,   0, 0, 0));
        tbl.push_back(mk("jr_r0",     0,  0, 1,  0,  0,  1,  0,   1,  0,  0,    0,    0,   0, 0, 0));

        // Reset: outputs forced low even with hazard inputs present.
        v = mk("rst_force", 8, 0, 1, 0, 0, 1, 1, 1, 8, 0, 1, 31, 0, 0, 0);
        v.rst = 1'b1;
        step(v);
        v = idle("rst_state"); v.e_busy = 0; v.e_cnt = 0;
        step(v);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Multi-cycle RAW: div dest 9 lat 4, consumer stalls 4 cycles.
        v = idle("raw_issue"); v.ismc = 1'b1; v.rw = 1'b1; v.dest = 9; v.lat = 4; v.clr = 1'b1;
        v.e_busy = 0;
        step(v);
        for (int c = 1; c <= 5; c++) begin
            v = idle($sformatf("raw_c%0d", c));
            v.rs = 9; v.urs = 1'b1;
            v.e_stall = (c <= 4) ? 1 : 0;
            v.e_busy  = (c <= 4) ? 1 : 0;
            v.e_cnt   = c - 1;
            step(v);
        end

        // WAW: lat 3 dest 10, then a single-cycle write to 10 waits for it.
        v = idle("waw_issue"); v.ismc = 1'b1; v.rw = 1'b1; v.dest = 10; v.lat = 3;
        step(v);
        for (int c = 1; c <= 4; c++) begin
            v = idle($sformatf("waw_c%0d", c));
            v.rw = 1'b1; v.dest = 10;
            v.e_stall = (c <= 3) ? 1 : 0;
            step(v);
        end

        // Structural: next multi-cycle op waits while the unit is busy, then issues.
        v = idle("st_issue"); v.ismc = 1'b1; v.rw = 1'b1; v.dest = 10; v.lat = 3;
        step(v);
        for (int c = 1; c <= 4; c++) begin
            v = idle($sformatf("st_c%0d", c));
            v.ismc = 1'b1; v.rw = 1'b1; v.dest = 11; v.lat = 2;
            v.e_stall = (c <= 3) ? 1 : 0;
            v.e_busy  = (c <= 3) ? 1 : 0;
            step(v);
        end
        v = idle("st_busy2"); v.e_busy = 1; step(v);
        v = idle("st_busy1"); v.e_busy = 1; step(v);
        v = idle("st_free");  v.e_busy = 0; step(v);

        // Latency 0 behaves as 1, and dest 0 still occupies the unit.
        v = idle("lat0_issue"); v.ismc = 1'b1; v.lat = 0; v.e_busy = 0; step(v);
        v = idle("lat0_busy"); v.e_busy = 1; step(v);
        v = idle("lat0_done"); v.e_busy = 0; step(v);

        // Hold inhibits issue.
        v = idle("hold_issue"); v.ismc = 1'b1; v.rw = 1'b1; v.dest = 13; v.lat = 5; v.hold = 1'b1;
        step(v);
        v = idle("hold_after"); v.rs = 13; v.urs = 1'b1; v.e_busy = 0; step(v);

        // Reset mid-operation discards the pending entry.
        v = idle("ro_issue"); v.ismc = 1'b1; v.rw = 1'b1; v.dest = 12; v.lat = 15; step(v);
        v = idle("ro_c1"); v.rs = 12; v.urs = 1'b1; v.e_stall = 1; v.e_busy = 1; step(v);
        v = idle("ro_c2"); v.e_busy = 1; step(v);
        v = mk("ro_rst", 12, 0, 1, 0, 0, 1, 0, 1, 12, 0, 1, 31, 0, 0, 0);
        v.rst = 1'b1; v.e_busy = -1;
        step(v);
        v = idle("ro_after"); v.rs = 12; v.urs = 1'b1; v.e_busy = 0; v.e_cnt = 0; step(v);

        // Saturation at 15, then clear (clear beats a concurrent stall).
        v = idle("sat_clr"); v.clr = 1'b1; step(v);
        for (int i = 0; i < 20; i++) begin
            v = mk($sformatf("sat_%0d", i), 8, 0, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0, 1, 0, 0);
            v.e_cnt = (i < 15) ? i : 15;
            step(v);
        end
        v = mk("sat_clrstall", 8, 0, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0, 1, 0, 0);
        v.clr = 1'b1; v.e_cnt = 15;
        step(v);
        v = idle("sat_cleared"); v.e_cnt = 0; step(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
